// File: rtl/complex_mux_arbiter_pkg.sv
// Shared definitions for the complex-sample round-robin arbiter:
// grant state encoding and complex field layout {re, im}.
package complex_mux_arbiter_pkg;

    localparam int unsigned CPLX_W      = 64;
    localparam int unsigned CPLX_HALF_W = CPLX_W / 2;
    localparam int unsigned CPLX_RE_MSB = CPLX_W - 1;
    localparam int unsigned CPLX_RE_LSB = CPLX_HALF_W;
    localparam int unsigned CPLX_IM_MSB = CPLX_HALF_W - 1;
    localparam int unsigned CPLX_IM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/complex_mux_arbiter_mux.sv
// 2:1 complex-sample mux; re and im halves are steered independently and passed bit-exact.
module complex_TwoxOne_mux
    import complex_mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = CPLX_W
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    output logic [DATA_W-1:0] o_data_c
);

    localparam int unsigned HALF_W = DATA_W / 2;

    logic [HALF_W-1:0] w_re;
    logic [HALF_W-1:0] w_im;

    assign w_re     = i_sel ? i_data1[DATA_W-1:HALF_W] : i_data0[DATA_W-1:HALF_W];
    assign w_im     = i_sel ? i_data1[HALF_W-1:0]      : i_data0[HALF_W-1:0];
    assign o_data_c = {w_re, w_im};

endmodule

// File: rtl/complex_mux_arbiter.sv
// Round-robin arbiter sharing one complex-sample path between two valid/ready requesters,
// with burst-limited grants and a single registered output stage.
module complex_mux_arbiter
    import complex_mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = CPLX_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic              mux_sel,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t        r_state, w_state_nxt;
    logic              r_last, w_last_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_hold, w_hold_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_src;

    logic              w_grant;
    logic              w_busy;
    logic              w_out_open;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_beat;
    logic              w_own_valid;
    logic              w_oth_valid;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_burst_end;
    logic [DATA_W-1:0] w_mux_data;

    assign w_grant     = (r_state == ST_G1);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_out_open  = ~r_out_valid | out_ready;
    // r_hold opens a one-cycle gap after a burst-limit handoff so the new grant settles first
    assign w_ready0    = (r_state == ST_G0) & ~r_hold & w_out_open;
    assign w_ready1    = (r_state == ST_G1) & ~r_hold & w_out_open;
    assign w_beat      = (in0_valid & w_ready0) | (in1_valid & w_ready1);
    assign w_own_valid = w_grant ? in1_valid : in0_valid;
    assign w_oth_valid = w_grant ? in0_valid : in1_valid;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_burst_end = w_beat & (w_cnt_inc == CNT_W'(MAX_BURST));

    complex_TwoxOne_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .i_sel    (w_grant),
        .i_data0  (in0_data),
        .i_data1  (in1_data),
        .o_data_c (w_mux_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (in0_valid && in1_valid) begin
                    w_state_nxt = r_last ? ST_G0 : ST_G1;
                end else if (in0_valid) begin
                    w_state_nxt = ST_G0;
                end else if (in1_valid) begin
                    w_state_nxt = ST_G1;
                end
            end
            ST_G0, ST_G1: begin
                if (w_oth_valid && (w_burst_end || !w_own_valid)) begin
                    w_state_nxt = w_grant ? ST_G0 : ST_G1;
                    w_last_nxt  = w_grant;
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = w_burst_end;
                end else if (!w_own_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = w_grant;
                    w_cnt_nxt   = '0;
                end else if (w_burst_end) begin
                    w_cnt_nxt = '0;
                end else if (w_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output stage: capture on beat, drain when downstream accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
        end else if (w_beat) begin
            r_out_data  <= w_mux_data;
            r_out_valid <= 1'b1;
            r_out_src   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in0_ready = w_ready0;
    assign in1_ready = w_ready1;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign mux_sel   = w_grant;
    assign busy      = w_busy;

endmodule

// File: tb/tb_complex_mux_arbiter.sv
// Randomized bench for complex_mux_arbiter against a transaction-level arbitration model.
module tb_complex_mux_arbiter;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in0_data, in1_data;
    logic              in0_valid, in1_valid;
    logic              in0_ready, in1_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_src;
    logic              mux_sel;
    logic              busy;

    complex_mux_arbiter #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .mux_sel   (mux_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the path, how many beats served in this grant,
    // who was served last, and what sits in the output register.
    int          m_owner;
    int          m_last;
    int          m_taken;
    bit          m_gap;
    bit          m_ov;
    logic [63:0] m_od;
    int          m_os;
    bit          src_v[2];
    logic [63:0] src_d[2];
    bit          src_acc[2];
    int          beats_in[2];
    int          beats_out;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_taken = 0; m_gap = 0;
        m_ov = 0; m_od = '0; m_os = 0;
        for (int x = 0; x < 2; x++) begin
            src_v[x] = 0; src_acc[x] = 0; src_d[x] = '0;
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data  = '0;   in1_data  = '0;
    endtask

    // One cycle: drive inputs at negedge, compare, then advance the model to the next edge.
    task automatic cycle(input int pv0, input int pv1, input int pordy);
        bit exp_rdy[2];
        bit beat;
        bit full;
        int o;
        bit new_gap;
        @(negedge clk);
        for (int x = 0; x < 2; x++) begin
            if (!src_v[x] || src_acc[x]) begin
                src_v[x] = ($urandom_range(99) < ((x == 0) ? pv0 : pv1));
                src_d[x] = {$urandom, $urandom};
            end
        end
        in0_valid = src_v[0]; in0_data = src_d[0];
        in1_valid = src_v[1]; in1_data = src_d[1];
        out_ready = ($urandom_range(99) < pordy);
        #1;
        for (int x = 0; x < 2; x++)
            exp_rdy[x] = (m_owner == x) && !m_gap && (!m_ov || out_ready);
        check("in0_ready", 64'(in0_ready), 64'(exp_rdy[0]));
        check("in1_ready", 64'(in1_ready), 64'(exp_rdy[1]));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("out_data", out_data, m_od);
            check("out_src", 64'(out_src), 64'(m_os));
        end
        check("busy", 64'(busy), 64'(m_owner != -1));
        if (m_owner != -1) check("mux_sel", 64'(mux_sel), 64'(m_owner == 1));

        beat = 0;
        src_acc[0] = 0; src_acc[1] = 0;
        if (m_owner != -1 && src_v[m_owner] && exp_rdy[m_owner]) begin
            beat = 1;
            src_acc[m_owner] = 1;
            beats_in[m_owner]++;
        end
        if (beat) begin
            m_od = src_d[m_owner]; m_os = m_owner; m_ov = 1;
        end else if (out_ready) begin
            if (m_ov) beats_out++;
            m_ov = 0;
        end else begin
            m_ov = m_ov;
        end
        if (beat && out_ready && m_ov) beats_out += 0;
        new_gap = 0;
        if (m_owner == -1) begin
            m_taken = 0;
            if (src_v[0] && src_v[1]) m_owner = 1 - m_last;
            else if (src_v[0])        m_owner = 0;
            else if (src_v[1])        m_owner = 1;
        end else begin
            o = m_owner;
            if (beat) m_taken++;
            full = beat && (m_taken == MAX_BURST);
            if (src_v[1-o] && (full || !src_v[o])) begin
                m_last = o; m_owner = 1 - o; m_taken = 0; new_gap = full;
            end else if (!src_v[o]) begin
                m_last = o; m_owner = -1; m_taken = 0;
            end else if (full) begin
                m_taken = 0;
            end
        end
        m_gap = new_gap;
    endtask

    task automatic run_phase(input int n, input int pv0, input int pv1, input int pordy);
        for (int i = 0; i < n; i++) cycle(pv0, pv1, pordy);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        beats_in[0] = 0; beats_in[1] = 0; beats_out = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in0_ready", 64'(in0_ready), 64'd0);
        check("rst_in1_ready", 64'(in1_ready), 64'd0);
        rst = 1'b0;

        run_phase(12, 100, 0, 100);   // single source streaming through burst wraps
        run_phase(4, 0, 0, 100);      // drain to idle
        run_phase(30, 100, 100, 100); // contention with burst handoffs
        run_phase(40, 100, 100, 40);  // contention under backpressure
        run_phase(60, 60, 60, 80);    // early releases and idle returns
        run_phase(300, 50, 50, 70);

        // Asynchronous reset mid-run: outputs must clear without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data",  out_data,       64'd0);
        check("arst_out_src",   64'(out_src),   64'd0);
        check("arst_busy",      64'(busy),      64'd0);
        check("arst_mux_sel",   64'(mux_sel),   64'd0);
        check("arst_in0_ready", 64'(in0_ready), 64'd0);
        check("arst_in1_ready", 64'(in1_ready), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_phase(20, 100, 100, 100); // first tie after reset goes to requester 0
        run_phase(300, 70, 40, 60);
        run_phase(6, 0, 0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
